// File: rtl/writeback_arbiter.sv
// -----------------------------------------------------------------------------
// writeback_arbiter
//
// Writer side of the integer register file. Single-cycle ALU results and
// buffered long-latency (LSU/MUL) results share the one register-file write
// port. The write is presented as a registered rd_addr/rd_data/rd_wren triple.
// A per-register pending scoreboard lets decode stall on registers that are
// still waiting for a long-latency result.
//
// Ports
//   clock_i, reset_ni        : clock (rising edge); synchronous active-HIGH reset
//   alu_valid_i/rd_i/data_i  : single-cycle ALU result
//   alu_stall_o              : ALU result not taken this cycle (upstream holds)
//   lsu_valid_i/rd_i/data_i  : long-op result, valid/ready handshake
//   lsu_ready_o              : result buffer can accept an entry
//   pend_set_i, pend_rd_i    : long op issued this cycle, with its destination
//   rs1/rs2_addr_i           : decode source-register queries
//   rs1/rs2_busy_o           : queried register awaits a long-op write
//   rd_addr_o/data_o/wren_o  : registered register-file write port
//   fifo_count_o             : result buffer occupancy
// -----------------------------------------------------------------------------
module writeback_arbiter #(
    parameter int XLEN       = 32,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 3
) (
    input  logic                          clock_i,
    input  logic                          reset_ni,
    input  logic                          alu_valid_i,
    input  logic [4:0]                    alu_rd_i,
    input  logic [XLEN-1:0]               alu_data_i,
    output logic                          alu_stall_o,
    input  logic                          lsu_valid_i,
    output logic                          lsu_ready_o,
    input  logic [4:0]                    lsu_rd_i,
    input  logic [XLEN-1:0]               lsu_data_i,
    input  logic                          pend_set_i,
    input  logic [4:0]                    pend_rd_i,
    input  logic [4:0]                    rs1_addr_i,
    input  logic [4:0]                    rs2_addr_i,
    output logic                          rs1_busy_o,
    output logic                          rs2_busy_o,
    output logic [4:0]                    rd_addr_o,
    output logic [XLEN-1:0]               rd_data_o,
    output logic                          rd_wren_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C      = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_MAX_C = SW'(STARVE_MAX);

    // Result buffer storage and control
    logic [4:0]      mem_rd_q   [FIFO_DEPTH];
    logic [XLEN-1:0] mem_data_q [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;

    logic [SW-1:0]   starve_q, starve_d;
    logic [31:0]     pend_q, pend_d;

    logic            rd_wren_q, rd_wren_d;
    logic [4:0]      rd_addr_q, rd_addr_d;
    logic [XLEN-1:0] rd_data_q, rd_data_d;

    logic            fifo_nempty_s;
    logic            force_s;
    logic            alu_ok_s;
    logic            push_s;
    logic            pop_s;
    logic            take_alu_s;
    logic [4:0]      head_rd_s;
    logic [XLEN-1:0] head_data_s;
    logic [31:0]     set_mask_s;
    logic [31:0]     clr_mask_s;

    assign fifo_nempty_s = (count_q != {CW{1'b0}});
    assign head_rd_s     = mem_rd_q[rd_ptr_q];
    assign head_data_s   = mem_data_q[rd_ptr_q];

    // Ready looks only at the registered count, never at a same-cycle pop.
    assign lsu_ready_o = ~reset_ni & (count_q < DEPTH_C);
    // Entries for x0 are accepted by the handshake but never stored.
    assign push_s      = lsu_valid_i & lsu_ready_o & (lsu_rd_i != 5'd0);

    assign force_s  = fifo_nempty_s & (starve_q == STARVE_MAX_C);
    assign alu_ok_s = alu_valid_i & (alu_rd_i != 5'd0);

    assign alu_stall_o = force_s & alu_valid_i & ~reset_ni;

    // Write-port selection: forced FIFO pop, then ALU, then FIFO, then idle.
    always_comb begin
        pop_s      = 1'b0;
        take_alu_s = 1'b0;
        if (force_s) begin
            pop_s = 1'b1;
        end else if (alu_ok_s) begin
            take_alu_s = 1'b1;
        end else if (fifo_nempty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s      = 1'b0;
            take_alu_s = 1'b0;
        end
    end

    // Next-state for the write port, buffer pointers and starve counter.
    always_comb begin
        rd_wren_d = 1'b0;
        rd_addr_d = 5'd0;
        rd_data_d = {XLEN{1'b0}};
        if (pop_s) begin
            rd_wren_d = 1'b1;
            rd_addr_d = head_rd_s;
            rd_data_d = head_data_s;
        end else if (take_alu_s) begin
            rd_wren_d = 1'b1;
            rd_addr_d = alu_rd_i;
            rd_data_d = alu_data_i;
        end else begin
            // Idle: address forced to x0 so bypass compares never hit.
            rd_wren_d = 1'b0;
            rd_addr_d = 5'd0;
            rd_data_d = {XLEN{1'b0}};
        end

        wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;

        case ({push_s, pop_s})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // Count ALU wins over a waiting head; clear on any pop or empty buffer.
        if (!fifo_nempty_s || pop_s) begin
            starve_d = {SW{1'b0}};
        end else if (take_alu_s && (starve_q != STARVE_MAX_C)) begin
            starve_d = starve_q + SW'(1);
        end else begin
            starve_d = starve_q;
        end
    end

    // Scoreboard update: clear on pop, then set, so a same-register set wins.
    always_comb begin
        set_mask_s = pend_set_i ? (32'd1 << pend_rd_i) : 32'd0;
        clr_mask_s = pop_s      ? (32'd1 << head_rd_s) : 32'd0;
        pend_d     = (pend_q & ~clr_mask_s) | set_mask_s;
        pend_d[0]  = 1'b0;
    end

    assign rs1_busy_o = pend_q[rs1_addr_i];
    assign rs2_busy_o = pend_q[rs2_addr_i];

    // Control and output registers with synchronous reset.
    always_ff @(posedge clock_i) begin
        if (reset_ni) begin
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            count_q   <= {CW{1'b0}};
            starve_q  <= {SW{1'b0}};
            pend_q    <= 32'd0;
            rd_wren_q <= 1'b0;
            rd_addr_q <= 5'd0;
            rd_data_q <= {XLEN{1'b0}};
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            starve_q  <= starve_d;
            pend_q    <= pend_d;
            rd_wren_q <= rd_wren_d;
            rd_addr_q <= rd_addr_d;
            rd_data_q <= rd_data_d;
        end
    end

    // Buffer payload storage; contents are meaningful only below count_q.
    always_ff @(posedge clock_i) begin
        if (push_s) begin
            mem_rd_q[wr_ptr_q]   <= lsu_rd_i;
            mem_data_q[wr_ptr_q] <= lsu_data_i;
        end else begin
            mem_rd_q[wr_ptr_q]   <= mem_rd_q[wr_ptr_q];
            mem_data_q[wr_ptr_q] <= mem_data_q[wr_ptr_q];
        end
    end

    assign rd_wren_o    = rd_wren_q;
    assign rd_addr_o    = rd_addr_q;
    assign rd_data_o    = rd_data_q;
    assign fifo_count_o = count_q;

endmodule

// File: tb/tb_writeback_arbiter.sv
// Directed bench for writeback_arbiter (XLEN=32, FIFO_DEPTH=2, STARVE_MAX=3).
// Inputs change 1 ns after the rising edge; outputs are checked 2 ns later.
module tb_writeback_arbiter;

    logic        clock_i = 1'b0;
    logic        reset_ni;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_i;
    logic [31:0] alu_data_i;
    logic        alu_stall_o;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_i;
    logic [31:0] lsu_data_i;
    logic        pend_set_i;
    logic [4:0]  pend_rd_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        rs1_busy_o;
    logic        rs2_busy_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;
    logic        rd_wren_o;
    logic [1:0]  fifo_count_o;

    int n_vec = 0;
    int n_err = 0;

    writeback_arbiter #(.XLEN(32), .FIFO_DEPTH(2), .STARVE_MAX(3)) dut (
        .clock_i      (clock_i),
        .reset_ni     (reset_ni),
        .alu_valid_i  (alu_valid_i),
        .alu_rd_i     (alu_rd_i),
        .alu_data_i   (alu_data_i),
        .alu_stall_o  (alu_stall_o),
        .lsu_valid_i  (lsu_valid_i),
        .lsu_ready_o  (lsu_ready_o),
        .lsu_rd_i     (lsu_rd_i),
        .lsu_data_i   (lsu_data_i),
        .pend_set_i   (pend_set_i),
        .pend_rd_i    (pend_rd_i),
        .rs1_addr_i   (rs1_addr_i),
        .rs2_addr_i   (rs2_addr_i),
        .rs1_busy_o   (rs1_busy_o),
        .rs2_busy_o   (rs2_busy_o),
        .rd_addr_o    (rd_addr_o),
        .rd_data_o    (rd_data_o),
        .rd_wren_o    (rd_wren_o),
        .fifo_count_o (fifo_count_o)
    );

    // 100 MHz clock.
    always #5 clock_i = ~clock_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge; inputs may then be driven.
    task automatic tick();
        @(posedge clock_i);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid_i = v;
        alu_rd_i    = rd;
        alu_data_i  = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid_i = v;
        lsu_rd_i    = rd;
        lsu_data_i  = d;
    endtask

    task automatic check_wr(input string tag, input logic w, input logic [4:0] a, input logic [31:0] d);
        check_eq({tag, ".wren"}, {31'd0, rd_wren_o}, {31'd0, w});
        check_eq({tag, ".addr"}, {27'd0, rd_addr_o}, {27'd0, a});
        check_eq({tag, ".data"}, rd_data_o, d);
    endtask

    initial begin
        reset_ni   = 1'b1;
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b1, 5'd3, 32'h3333);
        pend_set_i = 1'b0;
        pend_rd_i  = 5'd0;
        rs1_addr_i = 5'd0;
        rs2_addr_i = 5'd0;

        // Reset held two cycles with LSU offering data.
        settle();
        check_eq("rst.ready_during", {31'd0, lsu_ready_o}, 32'd0);
        tick();
        tick();
        settle();
        check_eq("rst.ready_during2", {31'd0, lsu_ready_o}, 32'd0);
        check_wr("rst", 1'b0, 5'd0, 32'd0);
        check_eq("rst.count", {30'd0, fifo_count_o}, 32'd0);
        check_eq("rst.stall", {31'd0, alu_stall_o}, 32'd0);
        reset_ni = 1'b0;
        lsu(1'b0, 5'd0, 32'd0);
        settle();
        check_eq("rst.ready_after", {31'd0, lsu_ready_o}, 32'd1);

        // ALU alone.
        tick();
        alu(1'b1, 5'd5, 32'h1234);
        settle();
        check_eq("alu.stall", {31'd0, alu_stall_o}, 32'd0);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        settle();
        check_wr("alu.out", 1'b1, 5'd5, 32'h1234);
        tick();
        settle();
        check_wr("alu.idle", 1'b0, 5'd0, 32'd0);

        // Fill FIFO while ALU busy every cycle, then starvation forcing.
        alu(1'b1, 5'd1, 32'h100);
        lsu(1'b1, 5'd7, 32'hA);
        tick();
        alu(1'b1, 5'd2, 32'h200);
        lsu(1'b1, 5'd8, 32'hB);
        settle();
        check_wr("fill.a", 1'b1, 5'd1, 32'h100);
        check_eq("fill.count1", {30'd0, fifo_count_o}, 32'd1);
        check_eq("fill.ready1", {31'd0, lsu_ready_o}, 32'd1);
        tick();
        alu(1'b1, 5'd3, 32'h300);
        lsu(1'b0, 5'd0, 32'd0);
        settle();
        check_eq("full.count", {30'd0, fifo_count_o}, 32'd2);
        check_eq("full.ready", {31'd0, lsu_ready_o}, 32'd0);
        check_eq("full.stall_c", {31'd0, alu_stall_o}, 32'd0);
        tick();
        alu(1'b1, 5'd4, 32'h400);
        settle();
        check_eq("starve.stall_d", {31'd0, alu_stall_o}, 32'd0);
        tick();
        alu(1'b1, 5'd6, 32'h600);
        settle();
        check_wr("starve.win3", 1'b1, 5'd4, 32'h400);
        check_eq("starve.stall", {31'd0, alu_stall_o}, 32'd1);
        tick();
        settle();
        check_wr("starve.pop", 1'b1, 5'd7, 32'hA);
        check_eq("starve.count", {30'd0, fifo_count_o}, 32'd1);
        check_eq("starve.cnt_reset", {31'd0, alu_stall_o}, 32'd0);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        settle();
        check_wr("starve.alu_held", 1'b1, 5'd6, 32'h600);
        tick();
        settle();
        check_wr("drain.b", 1'b1, 5'd8, 32'hB);
        check_eq("drain.count", {30'd0, fifo_count_o}, 32'd0);

        // Scoreboard.
        pend_set_i = 1'b1;
        pend_rd_i  = 5'd9;
        rs1_addr_i = 5'd9;
        rs2_addr_i = 5'd10;
        settle();
        check_eq("sb.busy_before", {31'd0, rs1_busy_o}, 32'd0);
        tick();
        pend_set_i = 1'b0;
        alu(1'b1, 5'd11, 32'h11);
        lsu(1'b1, 5'd9, 32'h55);
        settle();
        check_eq("sb.busy_set", {31'd0, rs1_busy_o}, 32'd1);
        check_eq("sb.rs2_idle", {31'd0, rs2_busy_o}, 32'd0);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        settle();
        check_eq("sb.busy_queued", {31'd0, rs1_busy_o}, 32'd1);
        check_eq("sb.count", {30'd0, fifo_count_o}, 32'd1);
        tick();
        settle();
        check_wr("sb.write", 1'b1, 5'd9, 32'h55);
        check_eq("sb.busy_drop", {31'd0, rs1_busy_o}, 32'd0);

        // Same-register set and clear: set wins.
        pend_set_i = 1'b1;
        pend_rd_i  = 5'd9;
        alu(1'b1, 5'd12, 32'h12);
        lsu(1'b1, 5'd9, 32'h66);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        tick();
        pend_set_i = 1'b0;
        settle();
        check_wr("same.write", 1'b1, 5'd9, 32'h66);
        check_eq("same.busy", {31'd0, rs1_busy_o}, 32'd1);

        // x0 handling: dropped LSU entry; ALU x0 lets FIFO head through.
        alu(1'b1, 5'd13, 32'h13);
        lsu(1'b1, 5'd14, 32'hEE);
        tick();
        alu(1'b1, 5'd0, 32'hDEAD);
        lsu(1'b1, 5'd0, 32'h77);
        rs2_addr_i = 5'd0;
        settle();
        check_eq("x0.count_pre", {30'd0, fifo_count_o}, 32'd1);
        check_eq("x0.rs2_busy", {31'd0, rs2_busy_o}, 32'd0);
        tick();
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        settle();
        check_wr("x0.head", 1'b1, 5'd14, 32'hEE);
        check_eq("x0.count", {30'd0, fifo_count_o}, 32'd0);
        tick();
        settle();
        check_wr("x0.idle", 1'b0, 5'd0, 32'd0);

        // Reset mid-operation discards buffered results and pending bits.
        alu(1'b1, 5'd16, 32'h16);
        lsu(1'b1, 5'd15, 32'hF5);
        tick();
        lsu(1'b0, 5'd0, 32'd0);
        alu(1'b0, 5'd0, 32'd0);
        reset_ni = 1'b1;
        settle();
        check_eq("mid.ready", {31'd0, lsu_ready_o}, 32'd0);
        tick();
        reset_ni = 1'b0;
        settle();
        check_eq("mid.count", {30'd0, fifo_count_o}, 32'd0);
        check_eq("mid.busy9", {31'd0, rs1_busy_o}, 32'd0);
        check_wr("mid.out", 1'b0, 5'd0, 32'd0);
        tick();
        settle();
        check_wr("mid.no_stale", 1'b0, 5'd0, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writer side of the integer register file.
- Merges single-cycle ALU results and multi-cycle LSU/MUL results onto the one register-file write port, as a registered rd_addr/rd_data/rd_wren triple.
- Buffers long-latency results in a small FIFO.
- Keeps a per-register pending scoreboard so decode can stall on registers still awaiting a long-latency result.

Parameters:
- XLEN, 32, data width.
- FIFO_DEPTH, 2, long-op result buffer entries; must be a power of two, 2..8.
- STARVE_MAX, 3, consecutive cycles the FIFO head may lose to the ALU before it is forced through.

Ports:
- clock_i  in  1  single clock, rising edge
- reset_ni  in  1  synchronous, active-high reset
- alu_valid_i  in  1  ALU result valid this cycle
- alu_rd_i  in  5  ALU destination register
- alu_data_i  in  XLEN  ALU result
- alu_stall_o  out  1  ALU result not taken this cycle; upstream holds it
- lsu_valid_i  in  1  long-op result valid
- lsu_ready_o  out  1  FIFO can accept
- lsu_rd_i  in  5  long-op destination register
- lsu_data_i  in  XLEN  long-op result
- pend_set_i  in  1  long op issued this cycle
- pend_rd_i  in  5  destination register of the issued long op
- rs1_addr_i  in  5  decode query address 1
- rs2_addr_i  in  5  decode query address 2
- rs1_busy_o  out  1  rs1 has a pending long-op write
- rs2_busy_o  out  1  rs2 has a pending long-op write
- rd_addr_o  out  5  register-file write address
- rd_data_o  out  XLEN  register-file write data
- rd_wren_o  out  1  register-file write enable
- fifo_count_o  out  clog2(FIFO_DEPTH)+1  FIFO occupancy

Behaviour:
- Reset, synchronous and active-high: all of the following clear at the reset edge:
  - rd_wren_o=0, rd_addr_o=0, rd_data_o=0.
  - FIFO empty, fifo_count_o=0.
  - Pending bits all 0.
  - Starve counter 0, alu_stall_o=0.
- While reset is asserted, lsu_ready_o=0. Asserting reset mid-operation discards buffered results and all pending bits.
- Handshake: an LSU entry is accepted when lsu_valid_i && lsu_ready_o at the clock edge.
- lsu_ready_o = (count < FIFO_DEPTH), using the registered count only; it does not depend on a same-cycle pop.
- An accepted LSU entry with lsu_rd_i=0 is dropped and not enqueued.
- Selection, each cycle, in priority order:
  - (a) If starve_cnt==STARVE_MAX and FIFO is non-empty: alu_stall_o=1 and the FIFO head is popped.
  - (b) Else if alu_valid_i && alu_rd_i!=0: the ALU result is taken.
  - (c) Else if FIFO is non-empty: the head is popped.
  - (d) Else: idle.
- alu_stall_o is combinational and is asserted only in case (a) with alu_valid_i high.
- An ALU result with alu_rd_i=0 is consumed with no write and leaves the slot free for the FIFO.
- Output latency: the selected result appears on rd_*_o one cycle later, held for exactly one cycle.
- When idle, rd_wren_o=0 and rd_addr_o is forced to 0, so downstream bypass compares against x0 are harmless.
- Starve counter:
  - Increments when the FIFO is non-empty and case (b) wins.
  - Resets to 0 on any FIFO pop or when the FIFO is empty.
  - Saturates at STARVE_MAX.
- FIFO: circular with wrapping pointers.
  - Push and pop in the same cycle leaves the count unchanged.
  - Push is never accepted when full.
- Pending scoreboard: 32 bits; bit 0 is hardwired to 0.
  - pend_set_i sets bit pend_rd_i.
  - A FIFO pop clears bit[head.rd].
  - If set and clear hit the same register in the same cycle, set wins.
- rsN_busy_o = pend[rsN_addr_i], combinational, 0 for x0.
- A bit clears at the edge that loads rd_*_o, so busy drops in the same cycle rd_wren_o presents the value.

Test Plan:
- Reset: hold reset_ni=1 for 2 cycles with lsu_valid_i=1 -> lsu_ready_o=0, rd_wren_o=0, fifo_count_o=0; after release lsu_ready_o=1.
- ALU alone: alu_valid_i=1, rd=5, data=0x1234 -> next cycle rd_wren_o=1, rd_addr_o=5, rd_data_o=0x1234; following idle cycle rd_wren_o=0, rd_addr_o=0.
- Full FIFO: with DEPTH=2, push rd=7/0xA and rd=8/0xB while the ALU is busy every cycle -> lsu_ready_o=0, fifo_count_o=2.
- Starvation: continue the full-FIFO case -> after 3 ALU wins, alu_stall_o=1 and 0xA is written to x7; the counter resets.
- Scoreboard: pend_set_i rd=9, query rs1=9 -> rs1_busy_o=1.
  - LSU returns rd=9/0x55: busy stays 1 while the entry is queued.
  - Busy drops in the cycle rd_wren_o=1, rd_addr_o=9.
- Same-register set and clear: pop for x9 with pend_set_i rd=9 in the same cycle -> bit 9 stays 1.
- x0 handling: LSU entry with rd=0 -> not enqueued, count unchanged.
- ALU with rd=0 while the FIFO holds an entry -> FIFO head written that cycle.
